// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Sequential shift-and-add unsigned multiplier with an ASM controller
// (IDLE / SHIFTING / ADDING / DONE). Each zero bit of the multiplier costs one
// cycle and each one bit costs two. The operation stops at the multiplier's
// leading one. The product is registered and holds from DONE until the next
// accepted start.
//
// Optional feature, selected with the macro MULT_SIGNED_EN:
//   When it is defined, the input signed_mode is added. With signed_mode=1 the
//   operands are taken as two's complement. Their magnitudes are multiplied,
//   and the result is negated on the edge that enters DONE.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request; sampled only while ready=1
//   word1        multiplicand (L_WORD bits)
//   word2        multiplier   (L_WORD bits)
//   signed_mode  (MULT_SIGNED_EN only) operands are two's complement
//   product      registered result (2*L_WORD bits)
//   ready        block can accept a start
//   busy         multiplication in progress
//   done         one-cycle strobe on entry to DONE
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int L_WORD = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [L_WORD-1:0]     word1,
    input  logic [L_WORD-1:0]     word2,
`ifdef MULT_SIGNED_EN
    input  logic                  signed_mode,
`endif
    output logic [2*L_WORD-1:0]   product,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);

    localparam int P_WORD = 2 * L_WORD;
    localparam logic [L_WORD-1:0] ONE_W = L_WORD'(1);
    localparam logic [P_WORD-1:0] ONE_P = P_WORD'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFTING = 2'd1,
        S_ADDING   = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [P_WORD-1:0]   mcand_q, mcand_d;
    logic [L_WORD-1:0]   mplier_q, mplier_d;
    logic [P_WORD-1:0]   product_q, product_d;
    logic                done_q, done_d;
    logic                sign_q, sign_d;

    logic                neg1, neg2;
    logic [L_WORD-1:0]   mag1, mag2;
    logic                empty;
    logic [P_WORD-1:0]   sum;
    logic [P_WORD-1:0]   final_sum;

`ifdef MULT_SIGNED_EN
    assign neg1 = signed_mode & word1[L_WORD-1];
    assign neg2 = signed_mode & word2[L_WORD-1];
`else
    assign neg1 = 1'b0;
    assign neg2 = 1'b0;
`endif

    // Magnitudes are L_WORD-bit unsigned values, so the most negative operand
    // (-2^(L_WORD-1)) maps onto the representable value 2^(L_WORD-1).
    assign mag1  = neg1 ? (~word1 + ONE_W) : word1;
    assign mag2  = neg2 ? (~word2 + ONE_W) : word2;

    // A zero operand in either sign interpretation is still zero.
    assign empty = (word1 == '0) || (word2 == '0);

    assign sum       = product_q + mcand_q;
    // The sign is applied on the same edge that enters DONE, so latency does
    // not change.
    assign final_sum = sign_q ? (~sum + ONE_P) : sum;

    // NOTE: Every variable gets a default before the case. If a path left one
    // unassigned, synthesis would infer a latch to hold its old value.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        sign_d    = sign_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    product_d = '0;
                    if (empty) begin
                        // Flush: the result is known and the operands are not
                        // needed.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        mcand_d  = {{L_WORD{1'b0}}, mag1};
                        mplier_d = mag2;
                        sign_d   = neg1 ^ neg2;
                        state_d  = S_SHIFTING;
                    end
                end
            end
            S_SHIFTING: begin
                if (mplier_q == ONE_W) begin
                    // This is the leading one, so the last partial product is
                    // added here.
                    product_d = final_sum;
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                end else if (mplier_q[0]) begin
                    product_d = sum;
                    state_d   = S_ADDING;
                end else begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
            end
            S_ADDING: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                state_d  = S_SHIFTING;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: Sequential state uses non-blocking assignments. All registers
    // update together on the edge, and the ordering between blocks cannot
    // leak into the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            done_q    <= done_d;
            sign_q    <= sign_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q == S_SHIFTING) || (state_q == S_ADDING);
    assign ready   = ((state_q == S_IDLE) && !reset) || (state_q == S_DONE);

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential shift-and-add unsigned multiplier driven by an ASM controller with IDLE/SHIFTING/ADDING/DONE states. Latency depends on the data: zero bits of the multiplier take one cycle, one bits take two, and the block stops at the multiplier's leading one. It succeeds the fixed 4-bit multiplier in the arithmetic datapath library. It adds a registered product, a done strobe, a busy flag, and start-while-busy protection.

Parameters:
L_WORD, 8, operand width in bits (>= 2); product is 2*L_WORD bits.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
word1  input  L_WORD  multiplicand
word2  input  L_WORD  multiplier
product  output  2*L_WORD  registered result; held from DONE until the next accepted start
ready  output  1  (state==IDLE && !reset) || state==DONE
busy  output  1  state==SHIFTING || state==ADDING
done  output  1  registered; high for exactly one cycle on entry to DONE

Behaviour:
- Reset is asynchronous, active-high; clock is clock. Reset forces: state=IDLE, multiplicand=0, multiplier=0, product=0, done=0, busy=0. ready=0 while reset is high.
- Internal registers: multiplicand is 2*L_WORD wide and zero-extended on load; multiplier is L_WORD wide.
- empty = (word1==0) || (word2==0), combinational on the inputs.
- IDLE and DONE share the same behaviour:
  - start=0: stay; product and done-state are held.
  - start=1 and empty: flush (product<=0), go to DONE.
  - start=1 and !empty: load operands, product<=0, go to SHIFTING.
- SHIFTING, in priority order:
  - multiplier==1: product<=product+multiplicand, go to DONE.
  - multiplier[0]==1: product<=product+multiplicand, go to ADDING.
  - otherwise: multiplicand<<=1, multiplier>>=1, stay in SHIFTING.
- ADDING: multiplicand<<=1, multiplier>>=1, go to SHIFTING.
- Adder is 2*L_WORD bits wide. The final product always fits, so no overflow is possible.
- Latency: let k = index of the MSB one of word2 and p = popcount(word2). The state becomes DONE exactly 1+k+p rising edges after the accepting edge is counted as edge 1. An empty operand reaches DONE after 1 edge.
- start while busy=1 is ignored. Operand changes while busy have no effect, because the operands are captured at load.
- Back-to-back: start held high in DONE with nonzero operands reloads on the next edge. done re-pulses when DONE is re-entered.
- Flush from DONE to DONE: product<=0 and done pulses again.
- Reset asserted mid-operation: immediate abort to IDLE with all registers zero. No done pulse.
- Illegal state encodings recover to IDLE on the next edge.

Optional Feature:
MULT_SIGNED_EN:
- Defined:
  - Adds input port signed_mode (1 bit), sampled with start.
  - When signed_mode=1, word1 and word2 are two's complement. The block loads their magnitudes (L_WORD-bit unsigned, so -2^(L_WORD-1) is representable) and latches sign = word1[MSB]^word2[MSB].
  - Latency uses k and p of |word2|.
  - On the transition into DONE, product is written two's-complement negated if sign=1. This happens in the same edge, so latency is unchanged.
  - An empty operand gives 0, never -0 artefacts.
- Undefined: the port is absent and the block is unsigned-only, as above.

Test Plan:
1. L_WORD=8. Reset, then word1=13, word2=11 (k=3, p=3), start for 1 cycle -> busy for 6 cycles, DONE 7 edges after accept, product=143, done high for 1 cycle, ready=1.
2. word1=0, word2=200, start -> DONE after 1 edge, product=0, done pulse. Repeat from DONE with word1=7, word2=0 -> product stays 0, second done pulse.
3. word1=255, word2=255 -> product=65025 after 16 edges. word1=255, word2=128 (k=7, p=1) -> product=32640 after 9 edges.
4. Accept 6*5, then drive start=1 with word1=9, word2=9 for 3 cycles while busy -> ignored, product=30. Holding start in DONE then loads 9*9 -> product=81.
5. Assert reset during SHIFTING of 200*77 -> product=0, state IDLE, ready=0 while reset high and 1 after release. No done pulse. Next 3*4 -> 12.
6. With MULT_SIGNED_EN, signed_mode=1: -3*5 -> 0xFFF1 (-15); -128*-128 -> 16384; 127*-1 -> 0xFF81. Latency matches the magnitude formula.
